name_scroller: RTL



---
 rtl/name_scroller_if.sv | 28 ++
 rtl/name_scroller.sv | 120 ++++++++++++
 2 files changed

// File: rtl/name_scroller_if.sv
// Bus bundle for the seven-segment message scroller.
// Master writes the message and controls scrolling; slave drives the display.
interface name_scroller_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8
);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [3:0]              wr_data;
  logic                    mode;
  logic                    run;
  logic [7*NUM_DIGITS-1:0] hex;
  logic [AW-1:0]           offset;
  logic                    step;
  logic                    wrap;

  modport master (
    output wr_en, wr_addr, wr_data, mode, run,
    input  hex, offset, step, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, mode, run,
    output hex, offset, step, wrap
  );
endinterface

// File: rtl/name_scroller.sv
// Message buffer with a NUM_DIGITS-wide seven-segment window that is either
// static or scrolls left with wrap-around every TICK_DIV cycles.
module name_scroller #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000
) (
  input  logic clk,
  input  logic reset,
  name_scroller_if.slave bus
);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = 7 * NUM_DIGITS;

  localparam logic [AW:0]   ADDR_LIM = (AW+1)'(MSG_LEN);
  localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [3:0]    buf_q [MSG_LEN];
  logic [3:0]    buf_d [MSG_LEN];
  logic [AW-1:0] off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;
  logic [HW-1:0] hex_q, hex_d;

  // Active-low segment pattern, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg7(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = 7'b0001000;
      4'd11:   s = 7'b0000011;
      4'd12:   s = 7'b1000110;
      4'd13:   s = 7'b0100001;
      4'd14:   s = 7'b0000110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Buffer index shown on digit k; digit NUM_DIGITS-1 (leftmost) shows offset.
  function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] off, input int k);
    int t;
    t = (int'(off) + NUM_DIGITS - 1 - k) % MSG_LEN;
    return AW'(t);
  endfunction

  always_comb begin
    buf_d = buf_q;
    if (bus.wr_en && ({1'b0, bus.wr_addr} < ADDR_LIM)) begin
      buf_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Scroll control: counter runs only in scroll mode with run high.
  always_comb begin
    cnt_d  = cnt_q;
    off_d  = off_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (!bus.mode) begin
      cnt_d = '0;
      off_d = '0;
    end else if (bus.run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        step_d = 1'b1;
        if (off_q == OFF_LAST) begin
          off_d  = '0;
          wrap_d = 1'b1;
        end else begin
          off_d = off_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    hex_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hex_d[7*k +: 7] = seg7(buf_q[win_idx(off_q, k)]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= 4'd15;
      off_q  <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      hex_q  <= '1;
    end else begin
      buf_q  <= buf_d;
      off_q  <= off_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      hex_q  <= hex_d;
    end
  end

  assign bus.hex    = hex_q;
  assign bus.offset = off_q;
  assign bus.step   = step_q;
  assign bus.wrap   = wrap_q;
endmodule
